// File: rtl/game_ctrl.sv
// Game control: IDLE/PLAY/HIT/OVER/PAUSE state machine, move tick divider, plane collision, lives and score.
// Pause support is compiled in only when GAME_CTRL_PAUSE_EN is defined; otherwise the pause port is ignored.
module game_ctrl #(
   parameter int TICK_DIV   = 833333,
   parameter int PLANE_X    = 60,
   parameter int HIT_W      = 24,
   parameter int HIT_H      = 16,
   parameter int LIVES      = 3,
   parameter int INVULN     = 30,
   parameter int DIFF_SCORE = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       pause,
   input  logic [9:0] plane_y,
   input  logic [9:0] lava_x,
   input  logic [9:0] lava_y,
   input  logic [9:0] mountain1_x,
   input  logic [9:0] mountain1_y,
   input  logic [9:0] mountain2_x,
   input  logic [9:0] mountain2_y,
   input  logic [6:0] lava_score,
   input  logic [3:0] mountain_score,
   output logic       game_over,
   output logic       obj_resetn,
   output logic       move_tick,
   output logic       difficulty,
   output logic [7:0] total_score,
   output logic [2:0] lives,
   output logic       hit,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PLAY  = 3'd1,
      HIT   = 3'd2,
      OVER  = 3'd3,
      PAUSE = 3'd4
   } state_t;

   localparam logic [19:0] TICK_LAST   = 20'(TICK_DIV - 1);
   localparam logic [10:0] X_LO        = 11'(PLANE_X);
   localparam logic [10:0] X_HI        = 11'(PLANE_X + HIT_W);
   localparam logic [10:0] HALF_H      = 11'(HIT_H);
   localparam logic [2:0]  LIVES_INIT  = 3'(LIVES);
   localparam logic [7:0]  INVULN_INIT = 8'(INVULN);
   localparam logic [8:0]  DIFF_LEVEL  = 9'(DIFF_SCORE);

   state_t      state_reg;
   logic        start_d_reg;
   logic        pause_d_reg;
   logic [19:0] tick_reg;
   logic [7:0]  invuln_reg;
   logic [2:0]  lives_reg;
   logic        hit_reg;
   logic        move_tick_reg;
   logic        obj_resetn_reg;
   logic        game_over_reg;
   logic        difficulty_reg;
   logic [7:0]  total_score_reg;

   logic        start_rise;
   logic        pause_rise;
   logic [10:0] lava_dy;
   logic [10:0] lava_dist;
   logic        lava_hit;
   logic [9:0]  mtn_x [2];
   logic [9:0]  mtn_y [2];
   logic [1:0]  mtn_hit;
   logic        collide;
   logic [8:0]  score_sum;
   logic [7:0]  score_next;
   logic        ticking;

   assign start_rise = start & ~start_d_reg;

`ifdef GAME_CTRL_PAUSE_EN
   assign pause_rise = pause & ~pause_d_reg;
`else
   logic unused_pause;
   assign pause_rise   = 1'b0;
   assign unused_pause = pause ^ pause_d_reg;
`endif

   // Signed 11-bit difference folded to a magnitude for the vertical window.
   assign lava_dy   = {1'b0, lava_y} - {1'b0, plane_y};
   assign lava_dist = lava_dy[10] ? (~lava_dy + 11'd1) : lava_dy;
   assign lava_hit  = ({1'b0, lava_x} >= X_LO) && ({1'b0, lava_x} < X_HI) && (lava_dist < HALF_H);

   assign mtn_x[0] = mountain1_x;
   assign mtn_y[0] = mountain1_y;
   assign mtn_x[1] = mountain2_x;
   assign mtn_y[1] = mountain2_y;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_mtn
         assign mtn_hit[gi] = ({1'b0, mtn_x[gi]} >= X_LO) && ({1'b0, mtn_x[gi]} < X_HI)
                              && (({1'b0, plane_y} + HALF_H) >= {1'b0, mtn_y[gi]});
      end
   endgenerate

   assign collide    = lava_hit | (|mtn_hit);
   assign score_sum  = {2'b00, lava_score} + {5'b00000, mountain_score};
   assign score_next = score_sum[8] ? 8'hFF : score_sum[7:0];
   assign ticking    = (state_reg == PLAY) || (state_reg == HIT);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= IDLE;
         start_d_reg     <= 1'b0;
         pause_d_reg     <= 1'b0;
         tick_reg        <= '0;
         invuln_reg      <= '0;
         lives_reg       <= LIVES_INIT;
         hit_reg         <= 1'b0;
         move_tick_reg   <= 1'b0;
         obj_resetn_reg  <= 1'b1;
         game_over_reg   <= 1'b1;
         difficulty_reg  <= 1'b0;
         total_score_reg <= '0;
      end else begin
         start_d_reg    <= start;
         pause_d_reg    <= pause;
         hit_reg        <= 1'b0;
         obj_resetn_reg <= 1'b1;
         move_tick_reg  <= 1'b0;

         if (ticking) begin
            if (tick_reg == TICK_LAST) begin
               tick_reg      <= '0;
               move_tick_reg <= 1'b1;
            end else begin
               tick_reg <= tick_reg + 20'd1;
            end
         end else if (state_reg != PAUSE) begin
            tick_reg <= '0;
         end

         // Final score stays visible after game over until the next start.
         if ((state_reg != OVER) || start_rise) begin
            total_score_reg <= score_next;
         end
         if (ticking && ({1'b0, score_next} >= DIFF_LEVEL)) begin
            difficulty_reg <= 1'b1;
         end

         case (state_reg)
            IDLE, OVER: begin
               if (start_rise) begin
                  obj_resetn_reg <= 1'b0;
                  lives_reg      <= LIVES_INIT;
                  difficulty_reg <= 1'b0;
                  tick_reg       <= '0;
                  invuln_reg     <= '0;
                  state_reg      <= PLAY;
                  game_over_reg  <= 1'b0;
               end
            end
            PLAY: begin
               if (move_tick_reg && collide) begin
                  hit_reg   <= 1'b1;
                  lives_reg <= lives_reg - 3'd1;
                  if (lives_reg == 3'd1) begin
                     state_reg     <= OVER;
                     game_over_reg <= 1'b1;
                  end else begin
                     state_reg  <= HIT;
                     invuln_reg <= INVULN_INIT;
                  end
               end else if (pause_rise) begin
                  // Freeze the divider on entry so no tick leaks into PAUSE.
                  state_reg     <= PAUSE;
                  game_over_reg <= 1'b1;
                  tick_reg      <= tick_reg;
                  move_tick_reg <= 1'b0;
               end
            end
            HIT: begin
               if (move_tick_reg) begin
                  invuln_reg <= invuln_reg - 8'd1;
                  if (invuln_reg == 8'd1) begin
                     state_reg <= PLAY;
                  end
               end
            end
            PAUSE: begin
               if (pause_rise) begin
                  state_reg     <= PLAY;
                  game_over_reg <= 1'b0;
               end
            end
            default: begin
               state_reg     <= IDLE;
               game_over_reg <= 1'b1;
            end
         endcase
      end
   end

   assign game_over   = game_over_reg;
   assign obj_resetn  = obj_resetn_reg;
   assign move_tick   = move_tick_reg;
   assign difficulty  = difficulty_reg;
   assign total_score = total_score_reg;
   assign lives       = lives_reg;
   assign hit         = hit_reg;
   assign state       = state_reg;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with TICK_DIV=4, LIVES=3, INVULN=2, DIFF_SCORE=5.
// Pause expectations follow GAME_CTRL_PAUSE_EN when it is defined for the build.
module tb_game_ctrl;

   logic       clk;
   logic       reset;
   logic       start;
   logic       pause;
   logic [9:0] plane_y;
   logic [9:0] lava_x;
   logic [9:0] lava_y;
   logic [9:0] mountain1_x;
   logic [9:0] mountain1_y;
   logic [9:0] mountain2_x;
   logic [9:0] mountain2_y;
   logic [6:0] lava_score;
   logic [3:0] mountain_score;
   logic       game_over;
   logic       obj_resetn;
   logic       move_tick;
   logic       difficulty;
   logic [7:0] total_score;
   logic [2:0] lives;
   logic       hit;
   logic [2:0] state;

   int checks = 0;
   int errors = 0;

   game_ctrl #(
      .TICK_DIV(4),
      .LIVES(3),
      .INVULN(2),
      .DIFF_SCORE(5)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .pause(pause),
      .plane_y(plane_y),
      .lava_x(lava_x),
      .lava_y(lava_y),
      .mountain1_x(mountain1_x),
      .mountain1_y(mountain1_y),
      .mountain2_x(mountain2_x),
      .mountain2_y(mountain2_y),
      .lava_score(lava_score),
      .mountain_score(mountain_score),
      .game_over(game_over),
      .obj_resetn(obj_resetn),
      .move_tick(move_tick),
      .difficulty(difficulty),
      .total_score(total_score),
      .lives(lives),
      .hit(hit),
      .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end else begin
         $display("ok   %s = %0d", tag, got);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Advance to the next move_tick cycle, bounded to two tick periods.
   task automatic wait_tick();
      for (int i = 0; i < 8 && move_tick !== 1'b1; i++) step(1);
      chk("tick_seen", move_tick, 1);
   endtask

   task automatic set_obj(input logic [9:0] lx, input logic [9:0] ly,
                          input logic [9:0] m1x, input logic [9:0] m1y, input logic [9:0] py);
      lava_x      = lx;
      lava_y      = ly;
      mountain1_x = m1x;
      mountain1_y = m1y;
      plane_y     = py;
   endtask

   task automatic probe(input string tag, input logic [9:0] lx, input logic [9:0] ly,
                        input logic [9:0] m1x, input logic [9:0] m1y, input logic [9:0] py,
                        input logic exp_hit);
      set_obj(lx, ly, m1x, m1y, py);
      wait_tick();
      step(1);
      chk(tag, hit, exp_hit);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset = 1'b1; start = 1'b0; pause = 1'b0;
      lava_score = '0; mountain_score = '0;
      mountain2_x = 10'd500; mountain2_y = 10'd900;
      set_obj(10'd300, 10'd100, 10'd500, 10'd900, 10'd100);
      step(2);
      chk("rst_state", state, 0);
      chk("rst_game_over", game_over, 1);
      chk("rst_obj_resetn", obj_resetn, 1);
      chk("rst_move_tick", move_tick, 0);
      chk("rst_hit", hit, 0);
      chk("rst_difficulty", difficulty, 0);
      chk("rst_total", total_score, 0);
      chk("rst_lives", lives, 3);

      // Start game: one-cycle obj_resetn, then move_tick every 4th cycle.
      reset = 1'b0;
      step(1);
      chk("idle_game_over", game_over, 1);
      start = 1'b1;
      step(1);
      chk("start_state", state, 1);
      chk("start_obj_resetn", obj_resetn, 0);
      chk("start_game_over", game_over, 0);
      for (int i = 1; i <= 8; i++) begin
         step(1);
         if (i == 1) chk("obj_resetn_release", obj_resetn, 1);
         chk("tick_period", move_tick, ((i % 4) == 0) ? 1 : 0);
      end

      // Lava hit, then invulnerability over the next two ticks.
      set_obj(10'd70, 10'd100, 10'd500, 10'd900, 10'd110);
      step(1);
      chk("lava_hit", hit, 1);
      chk("lava_lives", lives, 2);
      chk("lava_state", state, 2);
      step(1);
      chk("hit_one_cycle", hit, 0);
      wait_tick();
      chk("invuln_t1_state", state, 2);
      step(1);
      chk("invuln_t1_hit", hit, 0);
      wait_tick();
      step(1);
      chk("invuln_t2_hit", hit, 0);
      chk("invuln_end_state", state, 1);
      chk("invuln_end_lives", lives, 2);
      set_obj(10'd300, 10'd100, 10'd500, 10'd900, 10'd110);

      // Score sum and sticky difficulty.
      lava_score = 7'd3;
      step(1);
      chk("score_3", total_score, 3);
      chk("diff_below", difficulty, 0);
      mountain_score = 4'd2;
      step(1);
      chk("score_5", total_score, 5);
      chk("diff_set", difficulty, 1);

      // Mountain 2 drains the remaining lives; score held in OVER.
      mountain2_x = 10'd65; mountain2_y = 10'd150; plane_y = 10'd140;
      wait_tick();
      step(1);
      chk("m2_hit1_lives", lives, 1);
      wait_tick(); step(1);
      wait_tick(); step(1);
      chk("m2_back_play", state, 1);
      wait_tick();
      step(1);
      chk("m2_hit2", hit, 1);
      chk("m2_over_state", state, 3);
      chk("m2_over_lives", lives, 0);
      chk("m2_over_game_over", game_over, 1);
      lava_score = '0; mountain_score = '0;
      step(1);
      chk("over_score_hold", total_score, 5);
      chk("over_diff_sticky", difficulty, 1);
      start = 1'b0;
      n = 0;
      for (int i = 0; i < 8; i++) begin
         step(1);
         if (move_tick === 1'b1) n++;
      end
      chk("over_no_ticks", n, 0);

      // Restart with mountain 1 overlapping: three hits end the game.
      mountain2_x = 10'd500; mountain2_y = 10'd900;
      set_obj(10'd300, 10'd100, 10'd65, 10'd150, 10'd140);
      start = 1'b1;
      step(1);
      chk("restart_state", state, 1);
      chk("restart_obj_resetn", obj_resetn, 0);
      chk("restart_lives", lives, 3);
      chk("restart_diff", difficulty, 0);
      chk("restart_total", total_score, 0);
      for (int k = 0; k < 3; k++) begin
         wait_tick();
         step(1);
         chk("m1_hit", hit, 1);
         chk("m1_lives", lives, 2 - k);
         if (k < 2) begin
            chk("m1_state_hit", state, 2);
            wait_tick(); step(1);
            wait_tick(); step(1);
            chk("m1_state_play", state, 1);
         end
      end
      chk("m1_over_state", state, 3);
      chk("m1_over_game_over", game_over, 1);
      n = 0;
      for (int i = 0; i < 8; i++) begin
         step(1);
         if (move_tick === 1'b1) n++;
      end
      chk("m1_over_no_ticks", n, 0);

      // Window boundaries.
      start = 1'b0;
      set_obj(10'd300, 10'd100, 10'd500, 10'd900, 10'd110);
      lava_score = 7'd4;
      step(1);
      start = 1'b1;
      step(1);
      chk("bnd_start_state", state, 1);
      chk("bnd_start_total", total_score, 4);
      chk("bnd_start_diff", difficulty, 0);
      probe("lava_x_84", 10'd84, 10'd100, 10'd500, 10'd900, 10'd110, 1'b0);
      probe("lava_x_59", 10'd59, 10'd100, 10'd500, 10'd900, 10'd110, 1'b0);
      probe("lava_dy_p16", 10'd70, 10'd126, 10'd500, 10'd900, 10'd110, 1'b0);
      probe("lava_dy_m16", 10'd70, 10'd94, 10'd500, 10'd900, 10'd110, 1'b0);
      probe("lava_edge", 10'd83, 10'd95, 10'd500, 10'd900, 10'd110, 1'b1);
      chk("lava_edge_lives", lives, 2);
      set_obj(10'd300, 10'd100, 10'd500, 10'd900, 10'd110);
      wait_tick(); step(1);
      wait_tick(); step(1);
      chk("bnd_back_play", state, 1);
      probe("mtn_x_84", 10'd300, 10'd100, 10'd84, 10'd156, 10'd140, 1'b0);
      probe("mtn_y_157", 10'd300, 10'd100, 10'd60, 10'd157, 10'd140, 1'b0);
      probe("mtn_edge", 10'd300, 10'd100, 10'd60, 10'd156, 10'd140, 1'b1);
      chk("mtn_edge_lives", lives, 1);
      chk("mtn_edge_state", state, 2);

      // Reset in HIT with one life left.
      reset = 1'b1; start = 1'b0;
      step(1);
      chk("midrst_state", state, 0);
      chk("midrst_lives", lives, 3);
      chk("midrst_total", total_score, 0);
      chk("midrst_obj_resetn", obj_resetn, 1);
      chk("midrst_game_over", game_over, 1);
      reset = 1'b0; lava_score = '0;
      set_obj(10'd300, 10'd100, 10'd500, 10'd900, 10'd110);
      step(1);

      // Pause: frozen divider resumes from its held count.
      start = 1'b1;
      step(1);
      chk("p_start_obj_resetn", obj_resetn, 0);
      step(1);
      pause = 1'b1;
      step(1);
`ifdef GAME_CTRL_PAUSE_EN
      chk("pause_state", state, 4);
      chk("pause_game_over", game_over, 1);
`else
      chk("pause_state", state, 1);
      chk("pause_game_over", game_over, 0);
`endif
      n = 0;
      for (int i = 0; i < 5; i++) begin
         step(1);
         if (move_tick === 1'b1) n++;
      end
`ifdef GAME_CTRL_PAUSE_EN
      chk("pause_ticks", n, 0);
`else
      chk("pause_ticks", n, 1);
`endif
      pause = 1'b0;
      step(1);
      pause = 1'b1;
      step(1);
      chk("resume_state", state, 1);
      chk("resume_game_over", game_over, 0);
      pause = 1'b0;
      step(1);
      chk("resume_mt1", move_tick, 0);
      step(1);
      chk("resume_mt2", move_tick, 0);
      step(1);
      chk("resume_mt3", move_tick, 1);

      // Collision and pause edge together: the hit wins.
      set_obj(10'd70, 10'd100, 10'd500, 10'd900, 10'd110);
      pause = 1'b1;
      step(1);
      chk("prio_hit", hit, 1);
      chk("prio_state", state, 2);
      step(1);
      chk("prio_state_after", state, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
